// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-generation scheduler: FSM states,
// default key width and the timeout-counter width helper.
package rsa_pkg;

  // Default width of the public and private key words.
  localparam int KEY_W_DEFAULT = 1024;

  // Scheduler phases: arbitrate, kick the engine, wait for it, hand back.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Bits needed to count from 0 up to and including the timeout value.
  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rsa_keygen_sched_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after
// rr_ptr, wrapping past the top index back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDW-1:0]     gnt_idx
);

  logic           found;
  logic [IDW-1:0] cand;

  // Walk the request vector starting at rr_ptr and keep the first hit.
  always_comb begin
    // NOTE: every variable driven here gets a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt_oh[cand] = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/rsa_keygen_sched.sv
// Shares one RSA key-generation engine among NUM_REQ requesters: round-robin
// arbitration, a single start pulse, a bounded wait for completion, and a
// valid/ready response after which the private-key copy is zeroized. Also
// owns the lockable debug view of the private key.
module rsa_keygen_sched
  import rsa_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int KEY_W   = KEY_W_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       eng_start,
  input  logic                       eng_done,
  input  logic [KEY_W-1:0]           eng_pub,
  input  logic [KEY_W-1:0]           eng_priv,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_err,
  output logic [KEY_W-1:0]           pub_key,
  output logic [KEY_W-1:0]           priv_key,
  input  logic                       dbg_mode,
  input  logic                       lock,
  output logic [KEY_W-1:0]           dbg_key,
  output logic                       locked
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = timer_width(TIMEOUT);

  localparam logic [TW-1:0]  TIMEOUT_V = TW'(TIMEOUT);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  state_e               state_q,   state_d;
  logic [NUM_REQ-1:0]   gnt_q,     gnt_d;
  logic [IDW-1:0]       rsp_id_q,  rsp_id_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [KEY_W-1:0]     pub_q,     pub_d;
  logic [KEY_W-1:0]     priv_q,    priv_d;
  logic [IDW-1:0]       rr_ptr_q,  rr_ptr_d;
  logic [TW-1:0]        timer_q,   timer_d;
  logic                 lock_q,    lock_d;

  logic [NUM_REQ-1:0]   arb_oh;
  logic [IDW-1:0]       arb_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx)
  );

  // Next-state and datapath update for the whole job lifecycle.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rsp_id_d  = rsp_id_q;
    rsp_err_d = rsp_err_q;
    pub_d     = pub_q;
    priv_d    = priv_q;
    rr_ptr_d  = rr_ptr_q;
    timer_d   = timer_q;
    // The lock is sticky: once seen it holds until reset.
    lock_d    = lock_q | lock;

    unique case (state_q)
      ST_IDLE: begin
        // Requests are only looked at here, so a job in flight is never
        // disturbed by other requesters.
        if (|req) begin
          gnt_d    = arb_oh;
          rsp_id_d = arb_idx;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // Completion takes priority over an expiring timer in the same cycle.
        if (eng_done) begin
          pub_d     = eng_pub;
          priv_d    = eng_priv;
          rsp_err_d = 1'b0;
          state_d   = ST_RESP;
        end else if (timer_q == TIMEOUT_V) begin
          pub_d     = '0;
          priv_d    = '0;
          rsp_err_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_RESP: begin
        // Dropping req does not cancel the job; only the handshake ends it.
        if (rsp_ready) begin
          pub_d    = '0;
          priv_d   = '0;
          gnt_d    = '0;
          rr_ptr_d = (rsp_id_q == LAST_ID) ? '0 : rsp_id_q + IDW'(1);
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the key registers are reset along with the control state
    // because leftover key material after reset would leak a secret.
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      rsp_id_q  <= '0;
      rsp_err_q <= 1'b0;
      pub_q     <= '0;
      priv_q    <= '0;
      rr_ptr_q  <= '0;
      timer_q   <= '0;
      lock_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rsp_id_q  <= rsp_id_d;
      rsp_err_q <= rsp_err_d;
      pub_q     <= pub_d;
      priv_q    <= priv_d;
      rr_ptr_q  <= rr_ptr_d;
      timer_q   <= timer_d;
      lock_q    <= lock_d;
    end
  end

  // Output decode; keys are masked whenever no valid response is presented.
  always_comb begin
    gnt       = gnt_q;
    rsp_id    = rsp_id_q;
    rsp_err   = rsp_err_q;
    locked    = lock_q;
    // Gated by rst so a reset landing in START never launches the engine.
    eng_start = (state_q == ST_START) && !rst;
    rsp_valid = (state_q == ST_RESP);
    pub_key   = rsp_valid ? pub_q : '0;
    priv_key  = (rsp_valid && !rsp_err_q) ? priv_q : '0;
    dbg_key   = (dbg_mode && !lock_q) ? priv_q : '0;
  end

endmodule

// File: tb/tb_rsa_keygen_sched.sv
// Self-checking bench for rsa_keygen_sched: directed sections plus random
// jobs, checked against a job-level model of arbitration, timing and keys.
module tb_rsa_keygen_sched;

  localparam int NR        = 4;
  localparam int KW        = 64;
  localparam int TIMEOUT_A = 16;
  localparam int TIMEOUT_B = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic          eng_done;
  logic [KW-1:0] eng_pub, eng_priv;
  logic          rsp_ready, dbg_mode, lock;

  logic [NR-1:0] gnt, gnt_b;
  logic          eng_start, eng_start_b;
  logic          rsp_valid, rsp_valid_b;
  logic [1:0]    rsp_id, rsp_id_b;
  logic          rsp_err, rsp_err_b;
  logic [KW-1:0] pub_key, pub_key_b, priv_key, priv_key_b, dbg_key, dbg_key_b;
  logic          locked, locked_b;

  int checks = 0;
  int errors = 0;

  // Model state: round-robin pointer, sticky lock, private-key register.
  int            rr_m;
  bit            lock_m;
  logic [KW-1:0] keyreg_m;

  rsa_keygen_sched #(.NUM_REQ(NR), .KEY_W(KW), .TIMEOUT(TIMEOUT_A)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .eng_start(eng_start),
    .eng_done(eng_done), .eng_pub(eng_pub), .eng_priv(eng_priv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .pub_key(pub_key), .priv_key(priv_key),
    .dbg_mode(dbg_mode), .lock(lock), .dbg_key(dbg_key), .locked(locked)
  );

  rsa_keygen_sched #(.NUM_REQ(NR), .KEY_W(KW), .TIMEOUT(TIMEOUT_B)) dut_b (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_b), .eng_start(eng_start_b),
    .eng_done(eng_done), .eng_pub(eng_pub), .eng_priv(eng_priv),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_id(rsp_id_b),
    .rsp_err(rsp_err_b), .pub_key(pub_key_b), .priv_key(priv_key_b),
    .dbg_mode(dbg_mode), .lock(lock), .dbg_key(dbg_key_b), .locked(locked_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [KW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // First requester at or after ptr, wrapping; -1 if none.
  function automatic int pick(input logic [NR-1:0] r, input int ptr);
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (ptr + k) % NR;
      if (r[j[1:0]]) return j;
    end
    return -1;
  endfunction

  function automatic logic [KW-1:0] dbg_exp();
    return (dbg_mode && !lock_m) ? keyreg_m : '0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '0; eng_done = 1'b0; rsp_ready = 1'b0;
    lock = 1'b0; dbg_mode = 1'b0; eng_pub = '0; eng_priv = '0;
    tick(); tick();
    rst = 1'b0;
    rr_m = 0; lock_m = 1'b0; keyreg_m = '0;
  endtask

  // One complete job on dut: grant, start, done after lat cycles from WAIT
  // entry (or timeout), hold cycles of backpressure, then the handshake.
  task automatic do_job(input logic [NR-1:0] r, input int lat,
                        input logic [KW-1:0] pub, input logic [KW-1:0] priv,
                        input int hold, input bit drop,
                        input int stray_at, input int lock_at);
    int w, starts, resp_k, last_k;
    bit err;
    logic [KW-1:0] exp_pub, exp_priv;
    w = pick(r, rr_m);
    req = r;
    tick();                                   // arbitration edge
    check("gnt_after_req", KW'(gnt), KW'(4'b0001 << w));
    check("rsp_id_grant", KW'(rsp_id), KW'(w));
    check("start_pulse", KW'(eng_start), KW'(1));
    check("valid_in_start", KW'(rsp_valid), '0);
    starts = int'(eng_start);
    if (drop) req = '0;
    tick();                                   // WAIT entry edge
    starts += int'(eng_start);
    err    = lat > TIMEOUT_A + 1;
    resp_k = err ? TIMEOUT_A + 1 : lat;
    last_k = (lat > resp_k) ? lat : resp_k;
    for (int k = 1; k <= last_k; k++) begin
      eng_done = (k == lat);
      eng_pub  = (k == lat) ? pub  : rnd64();
      eng_priv = (k == lat) ? priv : rnd64();
      tick();
      eng_done = 1'b0;
      starts += int'(eng_start);
      check("valid_timing", KW'(rsp_valid), KW'(k >= resp_k));
    end
    exp_pub  = err ? '0 : pub;
    exp_priv = err ? '0 : priv;
    keyreg_m = exp_priv;
    check("rsp_err", KW'(rsp_err), KW'(err));
    check("rsp_id", KW'(rsp_id), KW'(w));
    check("pub_key", pub_key, exp_pub);
    check("priv_key", priv_key, exp_priv);
    check("gnt_in_resp", KW'(gnt), KW'(4'b0001 << w));
    check("dbg_key_resp", dbg_key, dbg_exp());
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      if (h == stray_at) begin
        eng_done = 1'b1; eng_pub = rnd64(); eng_priv = rnd64();
      end
      if (h == lock_at) lock = 1'b1;
      check("dbg_key_pre", dbg_key, dbg_exp());
      tick();
      eng_done = 1'b0; lock = 1'b0;
      if (h == lock_at) lock_m = 1'b1;
      starts += int'(eng_start);
      check("hold_valid", KW'(rsp_valid), KW'(1));
      check("hold_gnt", KW'(gnt), KW'(4'b0001 << w));
      check("hold_pub", pub_key, exp_pub);
      check("hold_priv", priv_key, exp_priv);
      check("hold_dbg", dbg_key, dbg_exp());
      check("hold_locked", KW'(locked), KW'(lock_m));
    end
    rsp_ready = 1'b1;
    tick();                                   // handshake edge
    rsp_ready = 1'b0;
    req = '0;
    keyreg_m = '0;
    check("post_valid", KW'(rsp_valid), '0);
    check("post_gnt", KW'(gnt), '0);
    check("post_pub", pub_key, '0);
    check("post_priv", priv_key, '0);
    check("post_dbg", dbg_key, dbg_exp());
    check("start_count", KW'(starts), KW'(1));
    rr_m = (w + 1) % NR;
  endtask

  initial begin
    // Reset values.
    do_reset();
    check("rst_gnt", KW'(gnt), '0);
    check("rst_start", KW'(eng_start), '0);
    check("rst_valid", KW'(rsp_valid), '0);
    check("rst_id", KW'(rsp_id), '0);
    check("rst_err", KW'(rsp_err), '0);
    check("rst_pub", pub_key, '0);
    check("rst_priv", priv_key, '0);
    check("rst_dbg", dbg_key, '0);
    check("rst_locked", KW'(locked), '0);

    // Single job with the reference keys.
    do_job(4'b0001, 10, 64'h1234, 64'hABCD, 2, 1'b1, -1, -1);

    // Fairness: all request, immediate accept; grants 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 5; i++)
      do_job(4'b1111, 3 + i, rnd64(), rnd64(), 0, 1'b0, -1, -1);
    check("rr_after_fair", KW'(rr_m), KW'(1));

    // Backpressure with a stray completion and the debug view open.
    dbg_mode = 1'b1;
    do_job(4'b0110, 5, rnd64(), rnd64(), 7, 1'b0, 3, -1);
    dbg_mode = 1'b0;

    // Random jobs.
    for (int i = 0; i < 12; i++) begin
      logic [NR-1:0] r;
      r = NR'($urandom_range(1, (1 << NR) - 1));
      dbg_mode = $urandom_range(0, 1) == 1;
      do_job(r, $urandom_range(1, TIMEOUT_A + 5), rnd64(), rnd64(),
             $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), -1);
    end
    dbg_mode = 1'b0;

    // Tie at the timeout boundary (done wins), then one cycle late (timeout).
    do_job(4'b0010, TIMEOUT_A + 1, rnd64(), rnd64(), 1, 1'b0, -1, -1);
    do_job(4'b0100, TIMEOUT_A + 2, rnd64(), rnd64(), 1, 1'b0, -1, -1);

    // Debug lock: visible before the pulse, dark afterwards and in later jobs.
    dbg_mode = 1'b1;
    do_job(4'b1000, 4, rnd64(), rnd64(), 4, 1'b0, -1, 1);
    do_job(4'b0001, 2, rnd64(), rnd64(), 2, 1'b0, -1, -1);
    check("locked_sticky", KW'(locked), KW'(1));
    dbg_mode = 1'b0;

    // Timeout on the short-timeout instance; late done is ignored.
    do_reset();
    req = 4'b0001;
    tick();
    check("b_gnt", KW'(gnt_b), KW'(4'b0001));
    check("b_start", KW'(eng_start_b), KW'(1));
    req = '0;
    tick();                                   // WAIT entry
    for (int k = 1; k <= TIMEOUT_B + 1; k++) begin
      tick();
      check("b_valid_timing", KW'(rsp_valid_b), KW'(k == TIMEOUT_B + 1));
    end
    check("b_err", KW'(rsp_err_b), KW'(1));
    check("b_pub", pub_key_b, '0);
    check("b_priv", priv_key_b, '0);
    eng_done = 1'b1; eng_pub = rnd64(); eng_priv = rnd64();
    check("b_dbg_dark", dbg_key_b, '0);
    tick();
    eng_done = 1'b0;
    check("b_late_pub", pub_key_b, '0);
    check("b_late_priv", priv_key_b, '0);
    check("b_late_valid", KW'(rsp_valid_b), KW'(1));
    check("b_late_err", KW'(rsp_err_b), KW'(1));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("b_post_valid", KW'(rsp_valid_b), '0);

    // Reset landing in START must not launch the engine.
    do_reset();
    req = 4'b0100;
    tick();
    check("rs_gnt", KW'(gnt), KW'(4'b0100));
    rst = 1'b1; req = '0;
    #1;
    check("rs_no_start", KW'(eng_start), '0);
    tick();
    rst = 1'b0;
    check("rs_gnt_clr", KW'(gnt), '0);

    // Reset during WAIT clears everything; later done gives no response.
    lock = 1'b1;
    tick();
    lock = 1'b0;
    check("rw_locked_set", KW'(locked), KW'(1));
    req = 4'b0010;
    tick();
    req = '0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("rw_gnt", KW'(gnt), '0);
    check("rw_start", KW'(eng_start), '0);
    check("rw_valid", KW'(rsp_valid), '0);
    check("rw_id", KW'(rsp_id), '0);
    check("rw_err", KW'(rsp_err), '0);
    check("rw_locked", KW'(locked), '0);
    check("rw_dbg", dbg_key, '0);
    rst = 1'b0;
    tick();
    eng_done = 1'b1; eng_pub = rnd64(); eng_priv = rnd64();
    tick();
    eng_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rw_late_valid", KW'(rsp_valid), '0);
      check("rw_late_pub", pub_key, '0);
    end
    dbg_mode = 1'b1;
    #1;
    check("rw_late_dbg", dbg_key, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_keygen_sched.md
# rsa_keygen_sched

Scheduler that shares one RSA key-generation engine among NUM_REQ requesters. It arbitrates round-robin, issues a single start pulse to the engine, and waits for completion under a timeout. It returns the key pair to the granted requester over a valid/ready handshake, then zeroizes its private-key copy. It sits between the security clients and the keygen engine, and also owns the gated debug view of the private key.

## Interface
- NUM_REQ, 4: number of requesters; 2..8.
- KEY_W, 1024: width of public and private key words.
- TIMEOUT, 255: maximum number of WAIT cycles before the job is aborted; 1..65535.
- clk in 1: the only clock. All logic is on the rising edge.
- rst in 1: synchronous, active-high reset.
- req in NUM_REQ: level request, one bit per requester.
- gnt out NUM_REQ: one-hot grant, held from arbitration until the response handshake completes.
- eng_start out 1: one-cycle start pulse to the engine.
- eng_done in 1: one-cycle completion pulse from the engine.
- eng_pub in KEY_W: engine public key; sampled only on eng_done.
- eng_priv in KEY_W: engine private key; sampled only on eng_done.
- rsp_valid out 1: a response is available.
- rsp_ready in 1: the requester accepts the response.
- rsp_id out clog2(NUM_REQ): index of the granted requester.
- rsp_err out 1: 1 means the job timed out.
- pub_key out KEY_W: public key; valid while rsp_valid = 1, otherwise 0.
- priv_key out KEY_W: private key; valid while rsp_valid = 1 and rsp_err = 0, otherwise 0.
- dbg_mode in 1: debug view request.
- lock in 1: sets a sticky lock that is cleared only by rst.
- dbg_key out KEY_W: debug view of the private key; 0 unless dbg_mode = 1 and the lock is not set.
- locked out 1: state of the sticky lock.

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - If req is non-zero, pick the first set bit at or after rr_ptr, wrapping around.
  - Register the winner into gnt and rsp_id, then go to START.
- START:
  - Drive eng_start = 1, clear the timer, go to WAIT.
- WAIT, on eng_done = 1:
  - Capture eng_pub and eng_priv, set rsp_err = 0, go to RESP.
- WAIT, otherwise:
  - If timer = TIMEOUT, set rsp_err = 1, force both key registers to 0, go to RESP.
  - Else increment the timer.
  - If eng_done and timer = TIMEOUT occur in the same cycle, eng_done wins.
- RESP:
  - Drive rsp_valid = 1.
  - On rsp_valid & rsp_ready:
    - clear both key registers (zeroize);
    - clear gnt;
    - set rr_ptr = rsp_id + 1 modulo NUM_REQ;
    - go to IDLE.
- eng_done outside WAIT is ignored and does not change the key registers.
- If the granted requester drops req after grant, the job is not aborted; the response is still delivered and must be consumed.
- Requests from other requesters are not sampled until the scheduler returns to IDLE.
- dbg_key shows the captured private-key register while the debug gate (dbg_mode = 1, lock clear) is open. Setting the lock forces dbg_key to 0 in the next cycle, and it stays 0 until rst.
- Width rules:
  - The timer is clog2(TIMEOUT + 1) bits and never wraps.
  - rr_ptr wraps from NUM_REQ - 1 to 0.

## Timing
- Reset values:
  - state = IDLE, gnt = 0, eng_start = 0, rsp_valid = 0, rsp_id = 0, rsp_err = 0;
  - pub_key = 0, priv_key = 0, dbg_key = 0, locked = 0;
  - rr_ptr = 0, timer = 0.
- Reset asserted mid-job:
  - all state clears in the next cycle;
  - no eng_start is issued while rst = 1;
  - a later eng_done from the engine is ignored.
- Cycle-level sequence:
  - req is sampled at edge T; gnt is high from T+1.
  - eng_start is high during cycle T+1 only.
  - eng_done at edge D gives rsp_valid from D+1.
  - The handshake at edge H gives rsp_valid = 0 and gnt = 0 from H+1.
  - The earliest next grant is at H+2.
- Minimum turnaround: 4 cycles plus engine latency.
- Timeout: rsp_valid rises TIMEOUT + 1 cycles after the WAIT entry edge when no eng_done arrives.

## Structure
- Shared package rsa_pkg holds:
  - the state enum;
  - KEY_W_DEFAULT;
  - the timeout width helper.
- One sub-module, rr_arbiter: a combinational round-robin pick from req and rr_ptr, outputting a one-hot vector and an index.
- All registers live in the top-level FSM.

## Test plan
- Single job:
  - Stimulus: req = 0001; engine returns done 10 cycles after start with pub = 0x1234 and priv = 0xABCD.
  - Required response: gnt = 0001 one cycle after req; exactly one eng_start pulse; rsp_valid with rsp_id = 0, rsp_err = 0 and the keys shown; after the handshake, pub_key = priv_key = 0.
- Fairness:
  - Stimulus: req = 1111 held, rsp_ready = 1.
  - Required response: grants in order 0, 1, 2, 3, 0; exactly one eng_start per grant.
- Timeout:
  - Stimulus: TIMEOUT = 5; engine never completes.
  - Required response: rsp_valid with rsp_err = 1 and pub_key = priv_key = 0, six cycles after WAIT entry; a late eng_done is ignored.
- Backpressure:
  - Stimulus: rsp_ready = 0 for 7 cycles.
  - Required response: rsp_valid, gnt and the keys are held stable; a stray eng_done does not change the keys.
- Debug lock:
  - Stimulus: dbg_mode = 1 during RESP, then lock = 1 is pulsed.
  - Required response: dbg_key = priv before the lock; 0 from the next cycle onward, including during subsequent jobs, until rst.
- Reset during WAIT:
  - Stimulus: rst = 1 during WAIT.
  - Required response: all outputs return to their reset values; an eng_done arriving after reset produces no rsp_valid.
